rf_wb_port: RTL and testbench

Write-back port controller that drives the register file's single write port (`RFWr`, `WBSel`, `WD`). It merges single-cycle ALU results with long-latency LSU/MUL results, buffers LSU results in a small FIFO when the port is taken, and keeps a pending-destination scoreboard so the decode stage can stall on registers not yet written back. It sits between the EX/MEM result paths and the register file in the pipeline.

---
 rtl/rf_wb_port_if.sv | 32 +++
 rtl/rf_wb_port.sv | 119 +++++++++++
 tb/tb_rf_wb_port.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_port_if.sv
// Result, issue, hazard-check and register-file write signals of the write-back port.
interface rf_wb_port_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_a;
  logic [4:0]  chk_b;
  logic        hazard_a;
  logic        hazard_b;
  logic        RFWr;
  logic [4:0]  WBSel;
  logic [31:0] WD;
  logic        wb_busy;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, chk_a, chk_b,
    input  lsu_ready, hazard_a, hazard_b, RFWr, WBSel, WD, wb_busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, chk_a, chk_b,
    output lsu_ready, hazard_a, hazard_b, RFWr, WBSel, WD, wb_busy
  );
endinterface

// File: rtl/rf_wb_port.sv
// Register-file write-port controller: arbitrates ALU and buffered LSU results onto the
// single RF write port and tracks destinations still awaiting write-back.
module rf_wb_port #(
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  rf_wb_port_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [4:0]       fifo_rd_q   [DEPTH];
  logic [4:0]       fifo_rd_d   [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [31:0]      fifo_data_d [DEPTH];
  logic [31:0]      pending_q, pending_d;
  logic             rfwr_q, rfwr_d;
  logic [4:0]       wbsel_q, wbsel_d;
  logic [31:0]      wd_q, wd_d;

  logic        alu_eff, lsu_acc, fifo_empty, pop, bypass, push;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign bus.lsu_ready = rst_n & (count_q < FULL_CNT);
  assign head_rd       = fifo_rd_q[head_q];
  assign head_data     = fifo_data_q[head_q];

  always_comb begin
    alu_eff     = bus.alu_valid & (bus.alu_rd != 5'd0);
    lsu_acc     = bus.lsu_valid & bus.lsu_ready;
    fifo_empty  = (count_q == '0);
    pop         = 1'b0;
    bypass      = 1'b0;
    rfwr_d      = 1'b0;
    wbsel_d     = wbsel_q;
    wd_d        = wd_q;
    pending_d   = pending_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;

    if (alu_eff) begin
      rfwr_d  = 1'b1;
      wbsel_d = bus.alu_rd;
      wd_d    = bus.alu_data;
    end else if (!fifo_empty) begin
      pop     = 1'b1;
      rfwr_d  = (head_rd != 5'd0);
      wbsel_d = head_rd;
      wd_d    = head_data;
    end else if (lsu_acc) begin
      bypass  = 1'b1;
      rfwr_d  = (bus.lsu_rd != 5'd0);
      wbsel_d = bus.lsu_rd;
      wd_d    = bus.lsu_data;
    end

    // A long-latency result on the port retires its destination; a same-edge reissue re-arms it.
    if (pop || bypass) pending_d[wbsel_d] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) pending_d[bus.issue_rd] = 1'b1;
    pending_d[0] = 1'b0;

    push    = lsu_acc & ~bypass;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d  = pop  ? ptr_inc(head_q) : head_q;
    tail_d  = push ? ptr_inc(tail_q) : tail_q;
    if (push) begin
      fifo_rd_d[tail_q]   = bus.lsu_rd;
      fifo_data_d[tail_q] = bus.lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      pending_q <= '0;
      rfwr_q    <= 1'b0;
      wbsel_q   <= '0;
      wd_q      <= '0;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      pending_q <= pending_d;
      rfwr_q    <= rfwr_d;
      wbsel_q   <= wbsel_d;
      wd_q      <= wd_d;
    end
  end

  // Entry storage is only ever read below count_q, so it carries no reset.
  always_ff @(posedge clk) begin
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
  end

  assign bus.RFWr     = rfwr_q;
  assign bus.WBSel    = wbsel_q;
  assign bus.WD       = wd_q;
  assign bus.wb_busy  = (count_q != '0);
  assign bus.hazard_a = (bus.chk_a != 5'd0) &
                        (pending_q[bus.chk_a] | (rfwr_q & (wbsel_q == bus.chk_a)));
  assign bus.hazard_b = (bus.chk_b != 5'd0) &
                        (pending_q[bus.chk_b] | (rfwr_q & (wbsel_q == bus.chk_b)));

endmodule

// File: tb/tb_rf_wb_port.sv
// Self-checking bench for rf_wb_port: directed scenarios plus random traffic against a
// queue-based model of the write-back rules.
module tb_rf_wb_port;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;

  rf_wb_port_if bus();
  rf_wb_port #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.chk_a = '0; bus.chk_b = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.chk_a = 5'd3;
    #1;
    n_checks++; if ({bus.RFWr, bus.WBSel, bus.WD} !== 38'h0) begin n_fail++; $display("FAIL reset_port: got %h want 0", {bus.RFWr, bus.WBSel, bus.WD}); end
    n_checks++; if ({bus.lsu_ready, bus.wb_busy, bus.hazard_a, bus.hazard_b} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.lsu_ready, bus.wb_busy, bus.hazard_a, bus.hazard_b}); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.lsu_ready); end
    // traffic, then reset in the middle of it
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h22;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    tick();
    n_checks++; if ({bus.RFWr, bus.WBSel, bus.WD} !== {1'b1, 5'd1, 32'h11}) begin n_fail++; $display("FAIL pre_reset_port: got %h want %h", {bus.RFWr, bus.WBSel, bus.WD}, {1'b1, 5'd1, 32'h11}); end
    idle();
    bus.chk_a = 5'd4; bus.chk_b = 5'd1;
    #1;
    n_checks++; if ({bus.hazard_a, bus.hazard_b, bus.wb_busy} !== 3'b111) begin n_fail++; $display("FAIL pre_reset_flags: got %b want 111", {bus.hazard_a, bus.hazard_b, bus.wb_busy}); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.RFWr, bus.WBSel, bus.WD} !== 38'h0) begin n_fail++; $display("FAIL midreset_port: got %h want 0", {bus.RFWr, bus.WBSel, bus.WD}); end
    n_checks++; if ({bus.lsu_ready, bus.wb_busy, bus.hazard_a, bus.hazard_b} !== 4'b0000) begin n_fail++; $display("FAIL midreset_flags: got %b want 0000", {bus.lsu_ready, bus.wb_busy, bus.hazard_a, bus.hazard_b}); end
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++; if ({bus.RFWr, bus.wb_busy, bus.hazard_a} !== 3'b000) begin n_fail++; $display("FAIL post_reset_discard: got %b want 000", {bus.RFWr, bus.wb_busy, bus.hazard_a}); end
  endtask

  task automatic test_alu_only();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h12345678;
    tick();
    n_checks++; if ({bus.RFWr, bus.WBSel, bus.WD} !== {1'b1, 5'd5, 32'h12345678}) begin n_fail++; $display("FAIL alu_write: got %h want %h", {bus.RFWr, bus.WBSel, bus.WD}, {1'b1, 5'd5, 32'h12345678}); end
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hDEADBEEF;
    bus.chk_a = 5'd5;
    #1;
    n_checks++; if (bus.hazard_a !== 1'b1) begin n_fail++; $display("FAIL alu_port_hazard: got %b want 1", bus.hazard_a); end
    tick();
    n_checks++; if ({bus.RFWr, bus.WBSel, bus.WD} !== {1'b0, 5'd5, 32'h12345678}) begin n_fail++; $display("FAIL alu_rd0_hold: got %h want %h", {bus.RFWr, bus.WBSel, bus.WD}, {1'b0, 5'd5, 32'h12345678}); end
    idle();
    bus.chk_a = 5'd5;
    #1;
    n_checks++; if (bus.hazard_a !== 1'b0) begin n_fail++; $display("FAIL alu_hazard_clear: got %b want 0", bus.hazard_a); end
  endtask

  task automatic test_conflict();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hA;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'hB;
    #1;
    n_checks++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL conflict_ready: got %b want 1", bus.lsu_ready); end
    tick();
    n_checks++; if ({bus.RFWr, bus.WBSel, bus.WD, bus.wb_busy} !== {1'b1, 5'd3, 32'hA, 1'b1}) begin n_fail++; $display("FAIL conflict_alu_first: got %h want %h", {bus.RFWr, bus.WBSel, bus.WD, bus.wb_busy}, {1'b1, 5'd3, 32'hA, 1'b1}); end
    idle(); bus.chk_a = 5'd7; #1;
    n_checks++; if (bus.hazard_a !== 1'b1) begin n_fail++; $display("FAIL conflict_hazard_pending: got %b want 1", bus.hazard_a); end
    tick();
    n_checks++; if ({bus.RFWr, bus.WBSel, bus.WD, bus.wb_busy} !== {1'b1, 5'd7, 32'hB, 1'b0}) begin n_fail++; $display("FAIL conflict_lsu_second: got %h want %h", {bus.RFWr, bus.WBSel, bus.WD, bus.wb_busy}, {1'b1, 5'd7, 32'hB, 1'b0}); end
    idle(); bus.chk_a = 5'd7; #1;
    n_checks++; if (bus.hazard_a !== 1'b1) begin n_fail++; $display("FAIL conflict_hazard_port: got %b want 1", bus.hazard_a); end
    tick();
    idle(); bus.chk_a = 5'd7; #1;
    n_checks++; if ({bus.RFWr, bus.hazard_a} !== 2'b00) begin n_fail++; $display("FAIL conflict_done: got %b want 00", {bus.RFWr, bus.hazard_a}); end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp_rd [8];
    logic       exp_rdy [6];
    logic       exp_busy [8];
    int lsu_idx;
    exp_rd   = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd8, 5'd9, 5'd10, 5'd0};
    exp_rdy  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    lsu_idx = 0;
    for (int c = 0; c < 8; c++) begin
      logic [31:0] exp_wd;
      idle();
      bus.alu_valid = (c < 4);
      bus.alu_rd = 5'(20 + c);
      bus.alu_data = 32'h200 + 32'(20 + c);
      bus.lsu_valid = (lsu_idx < 3);
      bus.lsu_rd = 5'(8 + lsu_idx);
      bus.lsu_data = 32'h100 + 32'(8 + lsu_idx);
      #1;
      if (bus.lsu_valid && c < 6) begin
        n_checks++; if (bus.lsu_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL bp_ready c%0d: got %b want %b", c, bus.lsu_ready, exp_rdy[c]); end
      end
      if (bus.lsu_valid && bus.lsu_ready) lsu_idx++;
      tick();
      exp_wd = (c < 4) ? 32'h200 + 32'(exp_rd[c]) : 32'h100 + 32'(exp_rd[c]);
      if (c < 7) begin
        n_checks++; if ({bus.RFWr, bus.WBSel, bus.WD} !== {1'b1, exp_rd[c], exp_wd}) begin n_fail++; $display("FAIL bp_write c%0d: got %h want %h", c, {bus.RFWr, bus.WBSel, bus.WD}, {1'b1, exp_rd[c], exp_wd}); end
      end else begin
        n_checks++; if (bus.RFWr !== 1'b0) begin n_fail++; $display("FAIL bp_idle c%0d: got %b want 0", c, bus.RFWr); end
      end
      n_checks++; if (bus.wb_busy !== exp_busy[c]) begin n_fail++; $display("FAIL bp_busy c%0d: got %b want %b", c, bus.wb_busy, exp_busy[c]); end
    end
  endtask

  task automatic test_scoreboard_edge();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
    tick();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd12; bus.lsu_data = 32'hC;
    bus.chk_a = 5'd12;
    #1;
    n_checks++; if ({bus.hazard_a, bus.lsu_ready} !== 2'b11) begin n_fail++; $display("FAIL sb_before: got %b want 11", {bus.hazard_a, bus.lsu_ready}); end
    tick();
    n_checks++; if ({bus.RFWr, bus.WBSel, bus.WD} !== {1'b1, 5'd12, 32'hC}) begin n_fail++; $display("FAIL sb_write_c: got %h want %h", {bus.RFWr, bus.WBSel, bus.WD}, {1'b1, 5'd12, 32'hC}); end
    idle(); bus.chk_a = 5'd12;
    tick();
    idle(); bus.chk_a = 5'd12;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd12; bus.lsu_data = 32'hD;
    #1;
    n_checks++; if ({bus.RFWr, bus.hazard_a} !== 2'b01) begin n_fail++; $display("FAIL sb_set_wins: got %b want 01", {bus.RFWr, bus.hazard_a}); end
    tick();
    n_checks++; if ({bus.RFWr, bus.WBSel, bus.WD} !== {1'b1, 5'd12, 32'hD}) begin n_fail++; $display("FAIL sb_write_d: got %h want %h", {bus.RFWr, bus.WBSel, bus.WD}, {1'b1, 5'd12, 32'hD}); end
    idle(); bus.chk_a = 5'd12;
    tick();
    idle(); bus.chk_a = 5'd12; #1;
    n_checks++; if (bus.hazard_a !== 1'b0) begin n_fail++; $display("FAIL sb_cleared: got %b want 0", bus.hazard_a); end
    // rd=0 everywhere: never a hazard, never a write
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h5;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hE;
    #1;
    n_checks++; if ({bus.hazard_a, bus.hazard_b, bus.lsu_ready} !== 3'b001) begin n_fail++; $display("FAIL sb_rd0_before: got %b want 001", {bus.hazard_a, bus.hazard_b, bus.lsu_ready}); end
    tick();
    idle(); #1;
    n_checks++; if ({bus.RFWr, bus.wb_busy, bus.hazard_a, bus.hazard_b} !== 4'b0000) begin n_fail++; $display("FAIL sb_rd0_after: got %b want 0000", {bus.RFWr, bus.wb_busy, bus.hazard_a, bus.hazard_b}); end
  endtask

  task automatic test_random();
    ent_t        q[$];
    logic [4:0]  issued[$];
    logic [31:0] pend;
    logic        m_wr;
    logic [4:0]  m_sel;
    logic [31:0] m_wd;
    logic        offer;
    ent_t        o;
    ent_t        e;
    idle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    pend = '0; m_wr = 1'b0; m_sel = '0; m_wd = '0; offer = 1'b0; o = '0;
    for (int c = 0; c < 3000; c++) begin
      int          alu_pct;
      logic        av, iv, exp_rdy, acc, ha, hb;
      logic [4:0]  ard, ird;
      logic [31:0] adata;
      alu_pct = ((c / 400) % 2 == 1) ? 85 : 30;
      av = ($urandom_range(99) < alu_pct);
      ard = 5'($urandom_range(31));
      adata = $urandom;
      if (pend[ard]) av = 1'b0;
      iv = ($urandom_range(99) < 30);
      ird = 5'($urandom_range(31));
      if (pend[ird]) iv = 1'b0;
      if (!offer && $urandom_range(99) < 50) begin
        offer = 1'b1;
        if (issued.size() > 0 && $urandom_range(99) < 80) o.rd = issued.pop_front();
        else o.rd = 5'($urandom_range(31));
        o.data = $urandom;
      end
      bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = adata;
      bus.issue_valid = iv; bus.issue_rd = ird;
      bus.lsu_valid = offer; bus.lsu_rd = o.rd; bus.lsu_data = o.data;
      bus.chk_a = ($urandom_range(1) == 1) ? o.rd : 5'($urandom_range(31));
      bus.chk_b = 5'($urandom_range(31));
      #1;
      exp_rdy = (q.size() < DEPTH);
      ha = (bus.chk_a != 0) && (pend[bus.chk_a] || (m_wr && m_sel == bus.chk_a));
      hb = (bus.chk_b != 0) && (pend[bus.chk_b] || (m_wr && m_sel == bus.chk_b));
      n_checks++; if (bus.lsu_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.lsu_ready, exp_rdy); end
      n_checks++; if ({bus.hazard_a, bus.hazard_b} !== {ha, hb}) begin n_fail++; $display("FAIL rnd_hazard c%0d: got %b want %b", c, {bus.hazard_a, bus.hazard_b}, {ha, hb}); end
      // model of the edge: accepted results queue in order behind anything already waiting
      acc = offer && exp_rdy;
      if (acc) begin
        q.push_back(o);
        offer = 1'b0;
      end
      if (av && ard != 0) begin
        m_wr = 1'b1; m_sel = ard; m_wd = adata;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_wr = (e.rd != 0); m_sel = e.rd; m_wd = e.data;
        pend[e.rd] = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
      if (iv && ird != 0) begin
        pend[ird] = 1'b1;
        issued.push_back(ird);
      end
      pend[0] = 1'b0;
      tick();
      n_checks++; if (bus.RFWr !== m_wr) begin n_fail++; $display("FAIL rnd_rfwr c%0d: got %b want %b", c, bus.RFWr, m_wr); end
      if (m_wr) begin
        n_checks++; if ({bus.WBSel, bus.WD} !== {m_sel, m_wd}) begin n_fail++; $display("FAIL rnd_write c%0d: got %h want %h", c, {bus.WBSel, bus.WD}, {m_sel, m_wd}); end
      end
      n_checks++; if (bus.wb_busy !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, bus.wb_busy, (q.size() != 0)); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_conflict();
    test_backpressure();
    test_scoreboard_edge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
